// File: rtl/lb_button_pkg.sv
// Shared state encoding, counter width and default 100 MHz timing for the
// Lightbike push-button conditioners.
package lb_button_pkg;

    localparam int DEF_CW       = 27;
    localparam int DEF_DB_CNT   = 2500000;   // 25 ms
    localparam int DEF_HOLD_CNT = 50000000;  // 0.5 s
    localparam int DEF_REP_CNT  = 10000000;  // 0.1 s

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DB_PRESS   = 3'd1,
        PRESSED    = 3'd2,
        HOLD       = 3'd3,
        REPEAT     = 3'd4,
        DB_RELEASE = 3'd5,
        WAIT_LOW   = 3'd6
    } btn_state_t;

    // True in every state where the button counts as debounced-pressed.
    function automatic logic is_pressed_level(input btn_state_t s);
        return (s == PRESSED) || (s == HOLD) || (s == REPEAT) ||
               (s == DB_RELEASE) || (s == WAIT_LOW);
    endfunction

endpackage

// File: rtl/lb_sync2.sv
// Generic two-flop synchroniser with asynchronous active-low clear, shared by
// all button inputs.
module lb_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lb_button_conditioner.sv
// Debounce / press / auto-repeat conditioner for one Nexys-3 push-button.
// Auto-repeat (HOLD/REPEAT, MCEN repeats, CCEN) is built only when LB_BTN_REPEAT_EN is defined.
module lb_button_conditioner
    import lb_button_pkg::*;
#(
    parameter int CW       = DEF_CW,
    parameter int DB_CNT   = DEF_DB_CNT,
    parameter int HOLD_CNT = DEF_HOLD_CNT,
    parameter int REP_CNT  = DEF_REP_CNT
) (
    input  logic CLK,
    input  logic RESET,
    input  logic PB,
    output logic DPB,
    output logic SCEN,
    output logic MCEN,
    output logic CCEN
);

    if (DB_CNT < 1 || HOLD_CNT < 1 || REP_CNT < 1 ||
        $clog2(DB_CNT + 1) > CW || $clog2(HOLD_CNT + 1) > CW ||
        $clog2(REP_CNT + 1) > CW) begin : g_bad_params
        $error("lb_button_conditioner: timing count out of range for CW");
    end

    localparam logic [CW-1:0] DB_LAST = CW'(DB_CNT - 1);
`ifdef LB_BTN_REPEAT_EN
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CNT - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REP_CNT - 1);
`endif

    logic          ps;
    btn_state_t    state, state_next;
    logic [CW-1:0] cnt, cnt_next;

    lb_sync2 #(.WIDTH(1)) u_sync (
        .clk   (CLK),
        .rst_n (RESET),
        .d     (PB),
        .q     (ps)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Every state change zeroes the shared counter; compare values stop it from wrapping.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + CW'(1);
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (ps) state_next = DB_PRESS;
            end
            DB_PRESS: begin
                if (!ps) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == DB_LAST) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end
            end
            PRESSED: begin
                cnt_next = '0;
`ifdef LB_BTN_REPEAT_EN
                state_next = HOLD;
`else
                state_next = WAIT_LOW;
`endif
            end
`ifdef LB_BTN_REPEAT_EN
            HOLD: begin
                if (!ps) begin
                    state_next = DB_RELEASE;
                    cnt_next   = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_next = REPEAT;
                    cnt_next   = '0;
                end
            end
            REPEAT: begin
                if (!ps) begin
                    state_next = DB_RELEASE;
                    cnt_next   = '0;
                end else if (cnt == REP_LAST) begin
                    cnt_next = '0;
                end
            end
`else
            WAIT_LOW: begin
                cnt_next = '0;
                if (!ps) state_next = DB_RELEASE;
            end
`endif
            DB_RELEASE: begin
                if (ps) begin
                    cnt_next = '0;
                end else if (cnt == DB_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        DPB  = is_pressed_level(state);
        SCEN = (state == PRESSED);
`ifdef LB_BTN_REPEAT_EN
        MCEN = (state == PRESSED) || ((state == REPEAT) && (cnt == REP_LAST));
        CCEN = (state == REPEAT);
`else
        MCEN = (state == PRESSED);
        CCEN = 1'b0;
`endif
    end

endmodule

// File: tb/tb_lb_button_conditioner.sv
// Directed bench for lb_button_conditioner with DB_CNT=4, HOLD_CNT=8, REP_CNT=3;
// expectations follow LB_BTN_REPEAT_EN as compiled.
module tb_lb_button_conditioner;

    localparam int B_DPB  = 3;
    localparam int B_SCEN = 2;
    localparam int B_MCEN = 1;
    localparam int B_CCEN = 0;

    logic CLK = 1'b0;
    logic RESET;
    logic PB;
    logic DPB, SCEN, MCEN, CCEN;

    int vectors     = 0;
    int miscompares = 0;

    // One entry per rising edge: {DPB, SCEN, MCEN, CCEN} sampled 1 ns later.
    logic [3:0] trace[$];

    always #5 CLK = ~CLK;

    lb_button_conditioner #(
        .CW       (8),
        .DB_CNT   (4),
        .HOLD_CNT (8),
        .REP_CNT  (3)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .PB    (PB),
        .DPB   (DPB),
        .SCEN  (SCEN),
        .MCEN  (MCEN),
        .CCEN  (CCEN)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic pb_val, input int cycles);
        PB = pb_val;
        repeat (cycles) begin
            @(posedge CLK);
            #1;
            trace.push_back({DPB, SCEN, MCEN, CCEN});
        end
    endtask

    function automatic int countHigh(input int b);
        int n = 0;
        foreach (trace[i]) if (trace[i][b]) n++;
        return n;
    endfunction

    function automatic int firstHigh(input int b, input int from);
        for (int i = from; i < trace.size(); i++) if (trace[i][b]) return i;
        return -1;
    endfunction

    function automatic int lastHigh(input int b);
        for (int i = trace.size() - 1; i >= 0; i--) if (trace[i][b]) return i;
        return -1;
    endfunction

    initial begin
        RESET = 1'b0;
        PB    = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset_dpb",  DPB,  0);
        checkOutput("reset_scen", SCEN, 0);
        checkOutput("reset_mcen", MCEN, 0);
        checkOutput("reset_ccen", CCEN, 0);
        RESET = 1'b1;
        applyStimulus(1'b0, 3);

        // Clean press: SCEN 7 edges after PB rise, DPB falls 7 edges after PB fall.
        $display("[TB] clean press");
        trace.delete();
        applyStimulus(1'b1, 10);
        applyStimulus(1'b0, 12);
        checkOutput("clean_first_scen", firstHigh(B_SCEN, 0), 6);
        checkOutput("clean_scen_count", countHigh(B_SCEN), 1);
        checkOutput("clean_first_mcen", firstHigh(B_MCEN, 0), 6);
        checkOutput("clean_mcen_count", countHigh(B_MCEN), 1);
        checkOutput("clean_first_dpb",  firstHigh(B_DPB, 0), 6);
        checkOutput("clean_last_dpb",   lastHigh(B_DPB), 15);
        checkOutput("clean_ccen_count", countHigh(B_CCEN), 0);

        $display("[TB] bounce");
        trace.delete();
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 10);
        checkOutput("bounce_scen_count", countHigh(B_SCEN), 0);
        checkOutput("bounce_mcen_count", countHigh(B_MCEN), 0);
        checkOutput("bounce_dpb_count",  countHigh(B_DPB), 0);
        trace.delete();
        applyStimulus(1'b1, 8);
        applyStimulus(1'b0, 12);
        checkOutput("bounce_recover_scen", firstHigh(B_SCEN, 0), 6);

        // Release bounce restarts the window two cycles in, pushing DPB fall back by 2.
        $display("[TB] release bounce");
        trace.delete();
        applyStimulus(1'b1, 10);
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 15);
        checkOutput("relbounce_scen_count", countHigh(B_SCEN), 1);
        checkOutput("relbounce_last_dpb",   lastHigh(B_DPB), 17);

        $display("[TB] long hold");
        trace.delete();
        applyStimulus(1'b1, 40);
        applyStimulus(1'b0, 15);
        checkOutput("hold_scen_count", countHigh(B_SCEN), 1);
        checkOutput("hold_last_dpb",   lastHigh(B_DPB), 45);
`ifdef LB_BTN_REPEAT_EN
        checkOutput("hold_first_ccen",  firstHigh(B_CCEN, 0), 15);
        checkOutput("hold_last_ccen",   lastHigh(B_CCEN), 41);
        checkOutput("hold_ccen_count",  countHigh(B_CCEN), 27);
        checkOutput("hold_first_rep",   firstHigh(B_MCEN, 7), 17);
        checkOutput("hold_second_rep",  firstHigh(B_MCEN, 18), 20);
        checkOutput("hold_mcen_count",  countHigh(B_MCEN), 10);
        checkOutput("hold_last_mcen",   lastHigh(B_MCEN), 41);
`else
        checkOutput("hold_mcen_count",  countHigh(B_MCEN), 1);
        checkOutput("hold_ccen_count",  countHigh(B_CCEN), 0);
        checkOutput("hold_dpb_count",   countHigh(B_DPB), 40);
`endif

        // Asynchronous reset while held, then a fresh debounce with PB still high.
        $display("[TB] reset while held");
        trace.delete();
        applyStimulus(1'b1, 20);
        checkOutput("prereset_dpb", DPB, 1);
`ifdef LB_BTN_REPEAT_EN
        checkOutput("prereset_ccen", CCEN, 1);
`endif
        RESET = 1'b0;
        #2;
        checkOutput("midreset_dpb",  DPB,  0);
        checkOutput("midreset_scen", SCEN, 0);
        checkOutput("midreset_mcen", MCEN, 0);
        checkOutput("midreset_ccen", CCEN, 0);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        trace.delete();
        applyStimulus(1'b1, 12);
        checkOutput("postreset_first_scen", firstHigh(B_SCEN, 0), 6);
        checkOutput("postreset_scen_count", countHigh(B_SCEN), 1);
        applyStimulus(1'b0, 12);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
